// File: rtl/lif_neuron.sv
// lif_neuron -- leaky integrate-and-fire post-synaptic neuron (4-input STDP demo).
//
// Integrates the weighted 4-bit pre-synaptic spike vector into an unsigned
// membrane potential with a linear leak. When the next potential reaches the
// threshold the neuron emits a one-cycle post_spike, reloads V_RESET and sits
// in a refractory period of REFRAC_CYCLES enabled cycles.
//
// Optional feature macro: LIF_ADAPT_THRESH_EN
//   defined   : threshold is a register, bumped by THRESH_STEP on every fire
//               (saturating) and decaying by 1 per non-firing integrating
//               cycle down to THRESH; held during refractory.
//   undefined : threshold is the constant THRESH.
//
// Ports
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   en          in   1   advance enable; low freezes all state
//   pre_spike   in   4   pre-synaptic spikes; bit i gates weight i
//   weight      in   16  packed weights: [15:12]=w0 [11:8]=w1 [7:4]=w2 [3:0]=w3
//   post_spike  out  1   registered one-cycle fire pulse
//   v_mem       out  VW  membrane potential register
//   refractory  out  1   high while in the refractory state
//   thresh_out  out  VW  threshold currently in use

module lif_neuron #(
    parameter int VW            = 8,
    parameter int THRESH        = 32,
    parameter int LEAK          = 1,
    parameter int V_RESET       = 0,
    parameter int REFRAC_CYCLES = 3,
    parameter int THRESH_STEP   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    pre_spike,
    input  logic [15:0]   weight,
    output logic          post_spike,
    output logic [VW-1:0] v_mem,
    output logic          refractory,
    output logic [VW-1:0] thresh_out
);

    localparam int CW = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES + 1) : 1;

    localparam logic [VW-1:0] THR_BASE = VW'(THRESH);
    localparam logic [VW-1:0] LEAK_V   = VW'(LEAK);
    localparam logic [VW-1:0] V_RST    = VW'(V_RESET);
    localparam logic [VW-1:0] V_MAX    = '1;
    localparam logic [CW-1:0] REFRAC_N = CW'(REFRAC_CYCLES);

    typedef enum logic {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [VW-1:0] thr;

    logic [5:0]    syn_sum;
    logic [VW-1:0] v_leak;
    logic [VW:0]   v_sum;
    logic [VW-1:0] v_next;
    logic          fire;

    // Weighted synapse sum: bit i of pre_spike selects nibble w_i.
    always_comb begin
        syn_sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (pre_spike[i]) begin
                syn_sum = syn_sum + 6'(weight[15 - 4*i -: 4]);
            end
        end
    end

    // Leak first (floored at 0), then add the input with saturation.
    always_comb begin
        v_leak = (v_mem > LEAK_V) ? (v_mem - LEAK_V) : '0;
        v_sum  = {1'b0, v_leak} + (VW+1)'(syn_sum);
        v_next = v_sum[VW] ? V_MAX : v_sum[VW-1:0];
        fire   = (v_next >= thr);
    end

`ifdef LIF_ADAPT_THRESH_EN
    logic [VW-1:0] thr_q;
    logic [VW:0]   thr_sum;
    logic [VW-1:0] thr_bumped;

    always_comb begin
        thr_sum    = {1'b0, thr_q} + (VW+1)'(THRESH_STEP);
        thr_bumped = thr_sum[VW] ? V_MAX : thr_sum[VW-1:0];
    end

    assign thr = thr_q;
`else
    assign thr = THR_BASE;
`endif

    assign thresh_out = thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INTEG;
            cnt        <= '0;
            v_mem      <= '0;
            post_spike <= 1'b0;
            refractory <= 1'b0;
`ifdef LIF_ADAPT_THRESH_EN
            thr_q      <= THR_BASE;
`endif
        end else if (!en) begin
            post_spike <= 1'b0;
        end else begin
            case (state)
                INTEG: begin
                    if (fire) begin
                        v_mem      <= V_RST;
                        post_spike <= 1'b1;
`ifdef LIF_ADAPT_THRESH_EN
                        thr_q      <= thr_bumped;
`endif
                        // With no refractory period the neuron stays
                        // integrating and may fire on consecutive cycles.
                        if (REFRAC_CYCLES != 0) begin
                            state      <= REFRAC;
                            cnt        <= REFRAC_N;
                            refractory <= 1'b1;
                        end
                    end else begin
                        v_mem      <= v_next;
                        post_spike <= 1'b0;
`ifdef LIF_ADAPT_THRESH_EN
                        if (thr_q > THR_BASE) begin
                            thr_q <= thr_q - 1'b1;
                        end
`endif
                    end
                end
                REFRAC: begin
                    v_mem      <= V_RST;
                    post_spike <= 1'b0;
                    cnt        <= cnt - 1'b1;
                    if (cnt <= CW'(1)) begin
                        state      <= INTEG;
                        refractory <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron -- self-checking bench for lif_neuron.
// Two instances share stimulus: dut_a with default parameters and dut_b with
// THRESH=255 (saturation behaviour). A behavioural model predicts each edge;
// predictions are queued when stimulus is driven and compared after the edge.

module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  pre;
    logic [15:0] weight;

    logic       post_a, refr_a, post_b, refr_b;
    logic [7:0] v_a, thr_a, v_b, thr_b;

    always #5 clk = ~clk;

    lif_neuron dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pre_spike  (pre),
        .weight     (weight),
        .post_spike (post_a),
        .v_mem      (v_a),
        .refractory (refr_a),
        .thresh_out (thr_a)
    );

    lif_neuron #(.THRESH(255)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pre_spike  (pre),
        .weight     (weight),
        .post_spike (post_b),
        .v_mem      (v_b),
        .refractory (refr_b),
        .thresh_out (thr_b)
    );

    typedef struct {
        int post;
        int v;
        int refr;
        int thr;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int m_v[2], m_st[2], m_cnt[2], m_thr[2], m_post[2];
    int m_base[2] = '{32, 255};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int syn(input logic [3:0] p, input logic [15:0] w);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            if (p[k]) s += int'((w >> (12 - 4*k)) & 16'h000F);
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_v[n] = 0; m_st[n] = 0; m_cnt[n] = 0; m_post[n] = 0;
            m_thr[n] = m_base[n];
        end
    endtask

    task automatic model_step(input bit e, input logic [3:0] p, input logic [15:0] w);
        int vl, vn;
        for (int n = 0; n < 2; n++) begin
            if (!e) begin
                m_post[n] = 0;
            end else if (m_st[n] == 1) begin
                m_post[n] = 0;
                m_v[n]    = 0;
                m_cnt[n]  = m_cnt[n] - 1;
                if (m_cnt[n] == 0) m_st[n] = 0;
            end else begin
                vl = (m_v[n] > 1) ? m_v[n] - 1 : 0;
                vn = vl + syn(p, w);
                if (vn > 255) vn = 255;
                if (vn >= m_thr[n]) begin
                    m_v[n] = 0; m_post[n] = 1; m_st[n] = 1; m_cnt[n] = 3;
`ifdef LIF_ADAPT_THRESH_EN
                    m_thr[n] = (m_thr[n] + 8 > 255) ? 255 : m_thr[n] + 8;
`endif
                end else begin
                    m_v[n] = vn; m_post[n] = 0;
`ifdef LIF_ADAPT_THRESH_EN
                    if (m_thr[n] > m_base[n]) m_thr[n] = m_thr[n] - 1;
`endif
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, queue the prediction, compare after the edge.
    task automatic step(input bit e, input logic [3:0] p, input logic [15:0] w);
        exp_t xa, xb;
        en = e; pre = p; weight = w;
        model_step(e, p, w);
        sb_a.push_back('{m_post[0], m_v[0], m_st[0], m_thr[0]});
        sb_b.push_back('{m_post[1], m_v[1], m_st[1], m_thr[1]});
        @(posedge clk);
        #1;
        if (sb_a.size() == 0 || sb_b.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            xa = sb_a.pop_front();
            xb = sb_b.pop_front();
            check("a.post", 32'(post_a), xa.post);
            check("a.v",    32'(v_a),    xa.v);
            check("a.refr", 32'(refr_a), xa.refr);
            check("a.thr",  32'(thr_a),  xa.thr);
            check("b.post", 32'(post_b), xb.post);
            check("b.v",    32'(v_b),    xb.v);
            check("b.refr", 32'(refr_b), xb.refr);
            check("b.thr",  32'(thr_b),  xb.thr);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    int leak_exp[7] = '{5, 4, 3, 2, 1, 0, 0};
    int sat_exp[4]  = '{60, 119, 178, 237};

    initial begin
        rst_n = 1'b0; en = 1'b0; pre = '0; weight = '0;
        model_reset();
        #3;
        check("rst.v",    32'(v_a),    0);
        check("rst.post", 32'(post_a), 0);
        check("rst.refr", 32'(refr_a), 0);
        check("rst.thr",  32'(thr_a),  32);
        check("rst.thr_b", 32'(thr_b), 255);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Integrate and fire with w0=15.
        step(1, 4'b0001, 16'hF000); check("if.v1", 32'(v_a), 15);
        step(1, 4'b0001, 16'hF000); check("if.v2", 32'(v_a), 29);
        step(1, 4'b0001, 16'hF000);
        check("if.post", 32'(post_a), 1);
        check("if.v0",   32'(v_a),    0);
        check("if.ref0", 32'(refr_a), 1);
`ifdef LIF_ADAPT_THRESH_EN
        check("ad.thr0", 32'(thr_a), 40);
`endif
        step(1, 4'b0001, 16'hF000); check("if.ref1", 32'(refr_a), 1); check("if.p1", 32'(post_a), 0);
        step(1, 4'b0001, 16'hF000); check("if.ref2", 32'(refr_a), 1);
        step(1, 4'b0001, 16'hF000); check("if.ref3", 32'(refr_a), 0); check("if.v3", 32'(v_a), 0);
        step(1, 4'b0001, 16'hF000); check("if.v4", 32'(v_a), 15);
`ifdef LIF_ADAPT_THRESH_EN
        check("ad.thr1", 32'(thr_a), 39);
`else
        check("thr.const", 32'(thr_a), 32);
`endif
        step(1, 4'b0001, 16'hF000);
`ifdef LIF_ADAPT_THRESH_EN
        check("ad.thr2", 32'(thr_a), 38);
`endif

        // Leak down to the floor.
        do_reset();
        step(1, 4'b0010, 16'h0500); check("leak0", 32'(v_a), leak_exp[0]);
        for (int i = 1; i < 7; i++) begin
            step(1, 4'b0000, 16'h0500);
            check("leak", 32'(v_a), leak_exp[i]);
        end

        // Saturation on the THRESH=255 instance.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 4'hF, 16'hFFFF);
            check("sat.v", 32'(v_b), sat_exp[i]);
        end
        step(1, 4'hF, 16'hFFFF);
        check("sat.post", 32'(post_b), 1);
        check("sat.v0",   32'(v_b),    0);

        // Enable freeze, then asynchronous reset right after a fire.
        do_reset();
        step(1, 4'b0001, 16'hF000); check("en.v1", 32'(v_a), 15);
        step(0, 4'b0001, 16'hF000); check("en.hold1", 32'(v_a), 15);
        step(0, 4'b0001, 16'hF000); check("en.hold2", 32'(v_a), 15); check("en.post", 32'(post_a), 0);
        step(1, 4'b0001, 16'hF000); check("en.v2", 32'(v_a), 29);
        step(1, 4'b0001, 16'hF000); check("en.fire", 32'(post_a), 1);
        rst_n = 1'b0;
        #1;
        check("arst.v",    32'(v_a),    0);
        check("arst.refr", 32'(refr_a), 0);
        check("arst.post", 32'(post_a), 0);
        model_reset();
        rst_n = 1'b1;
        step(1, 4'b0001, 16'hF000); check("arst.v1", 32'(v_a), 15);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7) != 0, 4'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
